// File: rtl/board_io_pkg.sv
// board_io_pkg
// Shared constants and helpers for the board I/O conditioner.
//   LED_OFF / LED_ON / LED_BLINK / LED_STRETCH : 2-bit per-LED mode encodings
//   cnt_width(max_val) : bits needed for a counter that must hold 0..max_val

package board_io_pkg;

  localparam logic [1:0] LED_OFF     = 2'b00;
  localparam logic [1:0] LED_ON      = 2'b01;
  localparam logic [1:0] LED_BLINK   = 2'b10;
  localparam logic [1:0] LED_STRETCH = 2'b11;

  // Never returns 0 so a counter of a degenerate range still has one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// One button channel: 2-flop synchroniser, stability counter, debounced level and
// one-cycle edge pulses.
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   btn_raw    in   raw asynchronous button pin
//   btn_level  out  debounced level (resets to IDLE)
//   btn_rise   out  one-cycle pulse on debounced 0->1
//   btn_fall   out  one-cycle pulse on debounced 1->0

module btn_debounce
  import board_io_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 1000,
  parameter logic        IDLE      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall
);

  localparam int unsigned    CW      = cnt_width(DB_CYCLES);
  // The counter never stores DB_CYCLES itself: the edge that would reach it
  // commits the new level instead.
  localparam logic [CW-1:0]  DB_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    // Any return to the current level clears the count, so bounces restart the window.
    if (sync2_q != level_q) begin
      if (cnt_q == DB_LAST) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
        fall_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= IDLE;
      sync2_q <= IDLE;
      level_q <= IDLE;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_level = level_q;
  assign btn_rise  = rise_q;
  assign btn_fall  = fall_q;

endmodule

// File: rtl/board_io_ctrl.sv
// board_io_ctrl
// Board I/O conditioner between the PLL clock domain and the SoC: reset
// sequencing with soft re-reset, debounced buttons with edge pulses, and LED
// drive with off/on/blink/pulse-stretch modes.
// Ports:
//   clk           in   system clock (PLL output)
//   reset_n       in   asynchronous active-low reset (e.g. PLL locked)
//   soft_rst_req  in   synchronous request to re-run the reset sequence
//   sys_reset_n   out  sequenced SoC reset, async assert / sync deassert
//   btn_raw       in   [N_BTN] raw button pins
//   btn_level     out  [N_BTN] debounced levels
//   btn_rise      out  [N_BTN] debounced 0->1 pulses
//   btn_fall      out  [N_BTN] debounced 1->0 pulses
//   led_mode      in   [2*N_LED] per-LED mode, bits [2i+1:2i] for LED i
//   led_trig      in   [N_LED] stretch triggers (rising-edge sensitive)
//   led           out  [N_LED] registered LED drive, active-high

module board_io_ctrl
  import board_io_pkg::*;
#(
  parameter int unsigned RST_CYCLES     = 255,
  parameter int unsigned N_BTN          = 2,
  parameter int unsigned N_LED          = 2,
  parameter int unsigned DB_CYCLES      = 1000,
  parameter logic        BTN_IDLE       = 1'b1,
  parameter int unsigned BLINK_DIV      = 6000000,
  parameter int unsigned STRETCH_CYCLES = 1200000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               soft_rst_req,
  output logic               sys_reset_n,
  input  logic [N_BTN-1:0]   btn_raw,
  output logic [N_BTN-1:0]   btn_level,
  output logic [N_BTN-1:0]   btn_rise,
  output logic [N_BTN-1:0]   btn_fall,
  input  logic [2*N_LED-1:0] led_mode,
  input  logic [N_LED-1:0]   led_trig,
  output logic [N_LED-1:0]   led
);

  // ---------------------------------------------------------------------------
  // Reset sequencer
  // ---------------------------------------------------------------------------
  localparam int unsigned    RCW     = cnt_width(RST_CYCLES);
  localparam logic [RCW-1:0] RST_MAX = RCW'(RST_CYCLES);

  logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
  logic           sys_rst_n_q, sys_rst_n_d;

  always_comb begin
    rst_cnt_d   = rst_cnt_q;
    sys_rst_n_d = sys_rst_n_q;
    if (soft_rst_req) begin
      rst_cnt_d   = '0;
      sys_rst_n_d = 1'b0;
    end else if (rst_cnt_q != RST_MAX) begin
      rst_cnt_d = rst_cnt_q + RCW'(1);
      if (rst_cnt_d == RST_MAX) begin
        sys_rst_n_d = 1'b1;
      end
    end
  end

  // Asserted asynchronously with reset_n, released only on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_cnt_q   <= '0;
      sys_rst_n_q <= 1'b0;
    end else begin
      rst_cnt_q   <= rst_cnt_d;
      sys_rst_n_q <= sys_rst_n_d;
    end
  end

  assign sys_reset_n = sys_rst_n_q;

  // ---------------------------------------------------------------------------
  // Buttons
  // ---------------------------------------------------------------------------
  for (genvar b = 0; b < N_BTN; b++) begin : g_btn
    btn_debounce #(
      .DB_CYCLES (DB_CYCLES),
      .IDLE      (BTN_IDLE)
    ) u_btn_debounce (
      .clk       (clk),
      .reset_n   (reset_n),
      .btn_raw   (btn_raw[b]),
      .btn_level (btn_level[b]),
      .btn_rise  (btn_rise[b]),
      .btn_fall  (btn_fall[b])
    );
  end

  // ---------------------------------------------------------------------------
  // Shared blink prescaler: one phase for all LEDs keeps blinkers in step.
  // ---------------------------------------------------------------------------
  localparam int unsigned    BCW        = cnt_width(BLINK_DIV - 1);
  localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_DIV - 1);

  logic [BCW-1:0] blink_cnt_q, blink_cnt_d;
  logic           blink_phase_q, blink_phase_d;

  always_comb begin
    blink_cnt_d   = blink_cnt_q + BCW'(1);
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  // ---------------------------------------------------------------------------
  // LED channels: stretch counter plus registered mode mux
  // ---------------------------------------------------------------------------
  localparam int unsigned    SCW          = cnt_width(STRETCH_CYCLES);
  localparam logic [SCW-1:0] STRETCH_LOAD = SCW'(STRETCH_CYCLES);

  for (genvar l = 0; l < N_LED; l++) begin : g_led
    logic [1:0]     mode;
    logic           trig_prev_q;
    logic [SCW-1:0] str_cnt_q, str_cnt_d;
    logic           led_q, led_d;

    assign mode = led_mode[2*l +: 2];

    // The stretch counter runs in every mode so a trigger seen while the LED is
    // in another mode still counts down.
    always_comb begin
      str_cnt_d = str_cnt_q;
      if (led_trig[l] && !trig_prev_q) begin
        str_cnt_d = STRETCH_LOAD;
      end else if (str_cnt_q != '0) begin
        str_cnt_d = str_cnt_q - SCW'(1);
      end
    end

    always_comb begin
      led_d = 1'b0;
      case (mode)
        LED_OFF:     led_d = 1'b0;
        LED_ON:      led_d = 1'b1;
        LED_BLINK:   led_d = blink_phase_q;
        LED_STRETCH: led_d = (str_cnt_q != '0);
        default:     led_d = 1'b0;
      endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        trig_prev_q <= 1'b0;
        str_cnt_q   <= '0;
        led_q       <= 1'b0;
      end else begin
        trig_prev_q <= led_trig[l];
        str_cnt_q   <= str_cnt_d;
        led_q       <= led_d;
      end
    end

    assign led[l] = led_q;
  end

endmodule

// File: tb/tb_board_io_ctrl.sv
// tb_board_io_ctrl
// Directed self-checking bench for board_io_ctrl with small parameters:
// RST_CYCLES=8, DB_CYCLES=4, BLINK_DIV=5, STRETCH_CYCLES=3, N_BTN=2, N_LED=2.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_board_io_ctrl;

  logic       clk;
  logic       reset_n;
  logic       soft_rst_req;
  logic       sys_reset_n;
  logic [1:0] btn_raw;
  logic [1:0] btn_level;
  logic [1:0] btn_rise;
  logic [1:0] btn_fall;
  logic [3:0] led_mode;
  logic [1:0] led_trig;
  logic [1:0] led;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Blink expectation after edges 1..16 (bit e-1): on for 6..10 and 16.
  logic [15:0] blink_tbl;

  board_io_ctrl #(
    .RST_CYCLES     (8),
    .N_BTN          (2),
    .N_LED          (2),
    .DB_CYCLES      (4),
    .BTN_IDLE       (1'b1),
    .BLINK_DIV      (5),
    .STRETCH_CYCLES (3)
  ) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .soft_rst_req (soft_rst_req),
    .sys_reset_n  (sys_reset_n),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .btn_rise     (btn_rise),
    .btn_fall     (btn_fall),
    .led_mode     (led_mode),
    .led_trig     (led_trig),
    .led          (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset_n      = 1'b0;
    soft_rst_req = 1'b0;
    btn_raw      = 2'b11;
    led_mode     = 4'b1010;
    led_trig     = 2'b00;
    blink_tbl    = 16'h83E0;

    // Reset state, with clocks running.
    step(2);
    check_val("rst_sys", sys_reset_n, 1'b0);
    check_val("rst_level", btn_level, 2'b11);
    check_val("rst_rise", btn_rise, 2'b00);
    check_val("rst_fall", btn_fall, 2'b00);
    check_val("rst_led", led, 2'b00);

    // Release; blink both LEDs and watch reset sequencing.
    reset_n = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      step(1);
      check_val($sformatf("blink_e%0d", e), led, blink_tbl[e-1] ? 2'b11 : 2'b00);
      if (e == 7) check_val("sys_e7", sys_reset_n, 1'b0);
      if (e == 8) check_val("sys_e8", sys_reset_n, 1'b1);
    end

    // Button 0 press: fall after 6 edges.
    btn_raw = 2'b10;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      if (k < 6) begin
        check_val($sformatf("b0_level_k%0d", k), btn_level, 2'b11);
        check_val($sformatf("b0_fall_k%0d", k), btn_fall, 2'b00);
      end else begin
        check_val("b0_level_k6", btn_level, 2'b10);
        check_val("b0_fall_k6", btn_fall, 2'b01);
        check_val("b0_rise_k6", btn_rise, 2'b00);
      end
    end
    step(1);
    check_val("b0_fall_done", btn_fall, 2'b00);
    check_val("b0_level_hold", btn_level, 2'b10);

    // Button 1 bounce: 3 cycles low must not register.
    btn_raw = 2'b00;
    step(3);
    btn_raw = 2'b10;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      check_val($sformatf("b1_bounce_level_k%0d", k), btn_level, 2'b10);
      check_val($sformatf("b1_bounce_pulse_k%0d", k), btn_rise | btn_fall, 2'b00);
    end
    btn_raw = 2'b00;
    step(5);
    check_val("b1_level_k5", btn_level, 2'b10);
    step(1);
    check_val("b1_level_k6", btn_level, 2'b00);
    check_val("b1_fall_k6", btn_fall, 2'b10);

    // Button 0 release: rise after 6 edges.
    btn_raw = 2'b01;
    step(5);
    check_val("b0_rise_k5", btn_rise, 2'b00);
    step(1);
    check_val("b0_rise_level", btn_level, 2'b01);
    check_val("b0_rise_k6", btn_rise, 2'b01);
    step(1);
    check_val("b0_rise_done", btn_rise, 2'b00);

    // Soft reset request, one cycle.
    soft_rst_req = 1'b1;
    step(1);
    check_val("soft_sys_req", sys_reset_n, 1'b0);
    soft_rst_req = 1'b0;
    step(7);
    check_val("soft_sys_e7", sys_reset_n, 1'b0);
    step(1);
    check_val("soft_sys_e8", sys_reset_n, 1'b1);
    check_val("soft_level_kept", btn_level, 2'b01);

    // Soft reset held for several cycles.
    soft_rst_req = 1'b1;
    step(3);
    check_val("soft_held_sys", sys_reset_n, 1'b0);
    soft_rst_req = 1'b0;
    step(7);
    check_val("soft_held_e7", sys_reset_n, 1'b0);
    step(1);
    check_val("soft_held_e8", sys_reset_n, 1'b1);

    // Stretch on LED 0, LED 1 on.
    led_mode = 4'b0111;
    step(1);
    check_val("mode_on", led, 2'b10);
    led_trig = 2'b01;
    step(1);
    led_trig = 2'b00;
    check_val("str_trig_edge", led, 2'b10);
    for (int k = 1; k <= 3; k++) begin
      step(1);
      check_val($sformatf("str_on_k%0d", k), led, 2'b11);
    end
    step(1);
    check_val("str_off", led, 2'b10);

    // Retrigger during the second stretched cycle.
    led_trig = 2'b01;
    step(1);
    led_trig = 2'b00;
    step(1);
    check_val("rtr_c1", led, 2'b11);
    led_trig = 2'b01;
    step(1);
    led_trig = 2'b00;
    check_val("rtr_c2", led, 2'b11);
    for (int k = 1; k <= 3; k++) begin
      step(1);
      check_val($sformatf("rtr_ext_k%0d", k), led, 2'b11);
    end
    step(1);
    check_val("rtr_off", led, 2'b10);

    led_mode = 4'b0000;
    step(1);
    check_val("mode_off", led, 2'b00);

    // Asynchronous reset mid-blink and mid-debounce.
    led_mode = 4'b0110;
    btn_raw  = 2'b00;
    step(3);
    check_val("pre_async_led1", led[1], 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("async_led", led, 2'b00);
    check_val("async_level", btn_level, 2'b11);
    check_val("async_sys", sys_reset_n, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/board_io_ctrl.md
# board_io_ctrl

Parametrised board I/O conditioner between the PLL/clock domain and the 6502 SoC on the HX8K board. It performs three jobs: power-on reset sequencing with a soft re-reset request, N-channel button synchronisation and debounce with edge pulses, and N-channel LED drive with off/on/blink/pulse-stretch modes. It generalises the fixed 255-cycle reset counter and the direct button/LED wiring of the board top into one reusable block.

## Interface
- RST_CYCLES, 255: clocks after reset_n release before sys_reset_n deasserts (≥1).
- N_BTN, 2: button channels.
- N_LED, 2: LED channels.
- DB_CYCLES, 1000: debounce stability window in clk cycles (≥1).
- BTN_IDLE, 1'b1: reset value of every btn_level bit (buttons are active-low on the board).
- BLINK_DIV, 6000000: clk cycles per blink half-period (≥2).
- STRETCH_CYCLES, 1200000: LED on-time per stretch trigger (≥1).
- clk  in  1  system clock (PLL output).
- reset_n  in  1  asynchronous, active-low reset (e.g. PLL locked); single clock domain.
- soft_rst_req  in  N/A→1  synchronous request to re-run the reset sequence.
- sys_reset_n  out  1  sequenced reset to the SoC; async assert, sync deassert.
- btn_raw  in  N_BTN  raw, asynchronous button pins.
- btn_level  out  N_BTN  debounced level.
- btn_rise  out  N_BTN  one-cycle pulse on debounced 0→1.
- btn_fall  out  N_BTN  one-cycle pulse on debounced 1→0.
- led_mode  in  2*N_LED  per-LED mode, bits [2i+1:2i] for LED i.
- led_trig  in  N_LED  synchronous stretch triggers.
- led  out  N_LED  registered LED drive, active-high.

## Operation
- Reset values (reset_n low): sys_reset_n 0, reset counter 0, btn_level all BTN_IDLE, both sync flops BTN_IDLE, btn_rise/btn_fall 0, debounce counters 0, blink prescaler 0, blink phase 0, stretch counters 0, led 0.
- Reset sequencer: counter increments each clk while below RST_CYCLES; sys_reset_n becomes 1 on the edge where the counter reaches RST_CYCLES, then holds. soft_rst_req sampled 1 clears counter and sys_reset_n on that edge; held high keeps sys_reset_n 0; sequence restarts the cycle after it drops. soft_rst_req does not affect buttons or LEDs.
- Debounce, per channel: 2-flop synchroniser, then a counter. If sync output ≠ btn_level, the counter increments; if equal, it clears. On the edge where it would reach DB_CYCLES, btn_level takes the sync value, the counter clears, and btn_rise or btn_fall pulses for exactly that one cycle. Any bounce within the window restarts it.
- LED modes: 00 off, 01 on, 10 blink (follows shared blink phase), 11 stretch. All LEDs in blink mode are in phase.
- Blink: prescaler counts 0..BLINK_DIV-1 and wraps; phase toggles on the wrapping edge. Period is 2*BLINK_DIV cycles.
- Stretch: a led_trig rising edge (0 in the previous cycle, 1 now) loads STRETCH_CYCLES. The counter decrements to 0. Retrigger while nonzero reloads the full value. The counter runs regardless of mode.

## Timing
- sys_reset_n: rises after the RST_CYCLES-th clk edge following reset_n deassertion.
- Button latency: btn_level changes DB_CYCLES+2 edges after the first edge sampling a stable new btn_raw value.
- led: one-cycle registered lag from mode change or blink phase change.
- Stretch: led high from the edge after the trigger edge for exactly STRETCH_CYCLES cycles.
- Mode change mid-stretch or mid-blink takes effect on the next edge. No glitch pulses are produced.
- reset_n assertion mid-operation: all state returns to reset values immediately (asynchronously).

## Structure
- Package board_io_pkg holds the LED mode constants LED_OFF, LED_ON, LED_BLINK and LED_STRETCH (2-bit), plus a clog2-based width helper for counters.
- Sub-module btn_debounce (parameters DB_CYCLES, IDLE) covers one channel: synchroniser, counter, level and edge pulses. It is instantiated N_BTN times via generate.
- The reset sequencer, blink prescaler and LED mux/stretch logic live in the top body.

## Test plan
Bench parameters: RST_CYCLES=8, DB_CYCLES=4, BLINK_DIV=5, STRETCH_CYCLES=3, N_BTN=2, N_LED=2.
- Release reset_n → sys_reset_n 0 through edge 7, 1 after edge 8. soft_rst_req pulsed for 1 cycle at any later point → sys_reset_n 0 next edge, then 1 again 8 edges after the request drops.
- btn_raw[0] 1→0 held → btn_level[0]=0 and btn_fall[0]=1 for one cycle, 6 edges after the change. btn_rise stays 0 and channel 1 is unchanged.
- btn_raw[1] toggled 1→0 for 3 cycles then back to 1 (bounce) → btn_level[1] stays 1 with no pulses. Then held 0 → fall after 6 edges.
- led_mode=10 on both LEDs from reset → led 1 after edge 6, 0 after edge 11, 1 after edge 16. Both bits are identical.
- led_mode[1:0]=11, led_trig[0] pulsed once → led[0] high for exactly 3 cycles. A retrigger during cycle 2 extends to 3 cycles after the retrigger.
- Assert reset_n low mid-blink and mid-debounce → led=0, btn_level=2'b11 and sys_reset_n=0 immediately, without waiting for a clk edge.
